// File: rtl/mdio_responder.sv
// Clause-22 MDIO slave: decodes read/write frames addressed to PHY_ADDR and
// serves them from a 32 x 16 register file, driving MDIO only for read TA/data.
module mdio_responder #(
    parameter logic [4:0]  PHY_ADDR = 5'h01,
    parameter logic [15:0] PHY_ID1  = 16'h0022,
    parameter logic [15:0] PHY_ID2  = 16'h1619,
    parameter int unsigned TIMEOUT  = 1024
) (
    input  logic        msoc_clk,
    input  logic        rstn,
    input  logic        i_emdc,
    input  logic        i_emdio,
    output logic        o_emdio,
    output logic        oe_emdio,
    input  logic        i_link,
    output logic        wr_strobe,
    output logic [4:0]  wr_addr,
    output logic [15:0] wr_data,
    output logic        rd_strobe
);

    localparam logic [3:0] S_IDLE  = 4'd0;
    localparam logic [3:0] S_ST    = 4'd1;
    localparam logic [3:0] S_OP    = 4'd2;
    localparam logic [3:0] S_PHYAD = 4'd3;
    localparam logic [3:0] S_REGAD = 4'd4;
    localparam logic [3:0] S_TA    = 4'd5;
    localparam logic [3:0] S_RDATA = 4'd6;
    localparam logic [3:0] S_WDATA = 4'd7;
    localparam logic [3:0] S_SKIP  = 4'd8;

    localparam int TW = $clog2(TIMEOUT + 1);

    logic r_mdc_s1, r_mdc_s2, r_mdc_d, r_mdc_rise;
    logic r_mdio_s1, r_mdio_s2, r_mdio_s3;

    logic [3:0]    r_state;
    logic [5:0]    r_pre_cnt;
    logic [4:0]    r_bit_cnt;
    logic          r_op_hi;
    logic          r_is_read;
    logic [4:0]    r_phyad;
    logic [4:0]    r_regad;
    logic [15:0]   r_shift;
    logic [TW-1:0] r_to_cnt;
    logic [15:0]   r_regs [32];

    logic          w_bit;
    logic [4:0]    w_regad_full;
    logic [15:0]   w_rd_word;
    logic          w_soft_rst;

    function automatic logic [15:0] f_rst_val(input int idx);
        case (idx)
            0:       return 16'h1140;
            1:       return 16'h7969;
            2:       return PHY_ID1;
            3:       return PHY_ID2;
            default: return 16'h0000;
        endcase
    endfunction

    // MDIO gets one extra stage so the sampled bit lines up with the registered MDC rise
    always_ff @(posedge msoc_clk or negedge rstn) begin
        if (!rstn) begin
            r_mdc_s1   <= 1'b0;
            r_mdc_s2   <= 1'b0;
            r_mdc_d    <= 1'b0;
            r_mdc_rise <= 1'b0;
            r_mdio_s1  <= 1'b1;
            r_mdio_s2  <= 1'b1;
            r_mdio_s3  <= 1'b1;
        end else begin
            r_mdc_s1   <= i_emdc;
            r_mdc_s2   <= r_mdc_s1;
            r_mdc_d    <= r_mdc_s2;
            r_mdc_rise <= r_mdc_s2 & ~r_mdc_d;
            r_mdio_s1  <= i_emdio;
            r_mdio_s2  <= r_mdio_s1;
            r_mdio_s3  <= r_mdio_s2;
        end
    end

    assign w_bit        = r_mdio_s3;
    assign w_regad_full = {r_regad[3:0], w_bit};
    assign w_soft_rst   = wr_strobe && (wr_addr == 5'd0) && wr_data[15];

    always_comb begin
        w_rd_word = r_regs[w_regad_full];
        if (w_regad_full == 5'd1) begin
            w_rd_word[2] = i_link;
        end
    end

    // Soft reset wins over the write itself, so reg0 bit 15 never reads back as 1
    always_ff @(posedge msoc_clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= f_rst_val(i);
            end
        end else if (w_soft_rst) begin
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= f_rst_val(i);
            end
        end else if (wr_strobe && (wr_addr != 5'd2) && (wr_addr != 5'd3)) begin
            r_regs[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge msoc_clk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= S_IDLE;
            r_pre_cnt <= 6'd0;
            r_bit_cnt <= 5'd0;
            r_op_hi   <= 1'b0;
            r_is_read <= 1'b0;
            r_phyad   <= 5'd0;
            r_regad   <= 5'd0;
            r_shift   <= 16'd0;
            r_to_cnt  <= '0;
            o_emdio   <= 1'b0;
            oe_emdio  <= 1'b0;
            wr_strobe <= 1'b0;
            wr_addr   <= 5'd0;
            wr_data   <= 16'd0;
            rd_strobe <= 1'b0;
        end else begin
            wr_strobe <= 1'b0;
            rd_strobe <= 1'b0;
            if ((r_state != S_IDLE) && !r_mdc_rise && (r_to_cnt == TW'(TIMEOUT - 1))) begin
                r_state   <= S_IDLE;
                r_pre_cnt <= 6'd0;
                r_to_cnt  <= '0;
                oe_emdio  <= 1'b0;
                o_emdio   <= 1'b0;
            end else begin
                if (r_mdc_rise || (r_state == S_IDLE)) begin
                    r_to_cnt <= '0;
                end else begin
                    r_to_cnt <= r_to_cnt + TW'(1);
                end
                if (r_mdc_rise) begin
                    case (r_state)
                        S_IDLE: begin
                            if (w_bit) begin
                                if (r_pre_cnt != 6'd32) r_pre_cnt <= r_pre_cnt + 6'd1;
                            end else if (r_pre_cnt == 6'd32) begin
                                r_state   <= S_ST;
                                r_pre_cnt <= 6'd0;
                            end else begin
                                r_pre_cnt <= 6'd0;
                            end
                        end
                        S_ST: begin
                            r_bit_cnt <= 5'd0;
                            r_state   <= w_bit ? S_OP : S_IDLE;
                        end
                        S_OP: begin
                            if (r_bit_cnt == 5'd0) begin
                                r_op_hi   <= w_bit;
                                r_bit_cnt <= 5'd1;
                            end else if (r_op_hi != w_bit) begin
                                r_is_read <= r_op_hi;
                                r_bit_cnt <= 5'd0;
                                r_state   <= S_PHYAD;
                            end else begin
                                r_state <= S_IDLE;
                            end
                        end
                        S_PHYAD: begin
                            r_phyad <= {r_phyad[3:0], w_bit};
                            if (r_bit_cnt == 5'd4) begin
                                r_bit_cnt <= 5'd0;
                                r_state   <= S_REGAD;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 5'd1;
                            end
                        end
                        S_REGAD: begin
                            r_regad <= w_regad_full;
                            if (r_bit_cnt == 5'd4) begin
                                r_bit_cnt <= 5'd0;
                                if (r_phyad != PHY_ADDR) begin
                                    r_state <= S_SKIP;
                                end else begin
                                    r_state <= S_TA;
                                    if (r_is_read) begin
                                        rd_strobe <= 1'b1;
                                        r_shift   <= w_rd_word;
                                    end
                                end
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 5'd1;
                            end
                        end
                        S_TA: begin
                            if (r_bit_cnt == 5'd0) begin
                                r_bit_cnt <= 5'd1;
                                if (r_is_read) begin
                                    oe_emdio <= 1'b1;
                                    o_emdio  <= 1'b0;
                                end
                            end else begin
                                r_bit_cnt <= 5'd0;
                                if (r_is_read) begin
                                    o_emdio <= r_shift[15];
                                    r_shift <= {r_shift[14:0], 1'b0};
                                    r_state <= S_RDATA;
                                end else begin
                                    r_state <= S_WDATA;
                                end
                            end
                        end
                        S_RDATA: begin
                            if (r_bit_cnt == 5'd15) begin
                                oe_emdio <= 1'b0;
                                o_emdio  <= 1'b0;
                                r_state  <= S_IDLE;
                            end else begin
                                o_emdio   <= r_shift[15];
                                r_shift   <= {r_shift[14:0], 1'b0};
                                r_bit_cnt <= r_bit_cnt + 5'd1;
                            end
                        end
                        S_WDATA: begin
                            r_shift <= {r_shift[14:0], w_bit};
                            if (r_bit_cnt == 5'd15) begin
                                wr_strobe <= 1'b1;
                                wr_addr   <= r_regad;
                                wr_data   <= {r_shift[14:0], w_bit};
                                r_state   <= S_IDLE;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 5'd1;
                            end
                        end
                        S_SKIP: begin
                            if (r_bit_cnt == 5'd17) begin
                                r_state <= S_IDLE;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 5'd1;
                            end
                        end
                        default: r_state <= S_IDLE;
                    endcase
                end
            end
        end
    end

endmodule

// File: doc/mdio_responder.md
# mdio_responder

PHY-side MDIO management responder: the slave end of the Clause-22 management bus that the Ethernet framing block drives by bit-banging MDC/MDIO from software. It decodes read and write frames addressed to its PHY address, serves them from an internal 32 x 16 register file, and drives MDIO only during the read turnaround and data phase. It sits in the PHY model and loopback test environment, and in any on-chip PHY shim.

## Interface
- PHY_ADDR, 5'h01: PHY address this responder answers to.
- PHY_ID1, 16'h0022: reset and read-only value of register 2.
- PHY_ID2, 16'h1619: reset and read-only value of register 3.
- TIMEOUT, 1024: msoc_clk cycles without an MDC rising edge that abort a frame in progress.

Ports:
- msoc_clk  in  1  sole clock; all logic on the rising edge.
- rstn  in  1  reset, asynchronous, active-low.
- i_emdc  in  1  MDC from the MAC, asynchronous to msoc_clk.
- i_emdio  in  1  resolved MDIO line value.
- o_emdio  out  1  MDIO drive value.
- oe_emdio  out  1  MDIO output enable; 1 = responder drives the line.
- i_link  in  1  live link status, reflected in reg 1 bit 2.
- wr_strobe  out  1  one-cycle pulse when a write frame commits.
- wr_addr  out  5  register address of the last committed write.
- wr_data  out  16  data of the last committed write.
- rd_strobe  out  1  one-cycle pulse when a read frame addressed to PHY_ADDR passes REGAD.

## Operation
- i_emdc and i_emdio each pass through a 2-flop synchronizer. An edge-detect flop generates mdc_rise. All MDIO sampling uses the synchronized MDIO value in the mdc_rise cycle.
- States: IDLE, ST, OP, PHYAD, REGAD, TA, RDATA, WDATA, SKIP.
- IDLE:
  - Counts consecutive sampled 1s; the counter saturates at 32.
  - A sampled 0 with count ≥ 32 goes to ST.
  - A sampled 0 with count < 32 clears the count.
- ST: sampled 1 goes to OP. Sampled 0 goes to IDLE with the count cleared.
- OP: two bits are collected. 10 = read, 01 = write. 00 or 11 goes to IDLE with the count cleared.
- PHYAD: five bits, MSB first. REGAD: five bits, MSB first.
- After REGAD, if PHYAD ≠ PHY_ADDR: go to SKIP, consume 18 more edges without driving or writing, then go to IDLE with the count cleared.
- Read, addressed (on the last REGAD edge): rd_strobe pulses and the register value is latched into a 16-bit shift register.
  - TA edge 1: line stays released.
  - After TA edge 1: oe_emdio=1, o_emdio=0.
  - After each following edge: shift out data[15] down to data[0].
  - After the edge that samples data[0]: oe_emdio=0, go to IDLE.
- Write, addressed: both TA bits are ignored. Sixteen data bits are shifted in, MSB first. On the 16th data edge:
  - wr_strobe pulses; wr_addr and wr_data update.
  - The register file updates, except regs 2 and 3, which are read-only (the strobe still fires).
- Register file contents:
  - Reset values: reg0 16'h1140, reg1 16'h7969 with bit 2 replaced by i_link on read, reg2 PHY_ID1, reg3 PHY_ID2, all others 0.
  - Writing reg0 with bit 15 = 1 restores all registers to their reset values the following cycle; bit 15 reads 0 afterwards.
- Timeout: TIMEOUT cycles with no mdc_rise outside IDLE forces oe_emdio=0 and IDLE with the count cleared. No write commits on timeout.
- After every completed frame, the responder returns to IDLE with the count cleared, so each frame needs a new 32-bit preamble.

## Timing
- Reset values: o_emdio=0, oe_emdio=0, wr_strobe=0, wr_addr=0, wr_data=0, rd_strobe=0, state IDLE, count 0.
- mdc_rise asserts 3 msoc_clk cycles after an MDC pin rise.
- o_emdio and oe_emdio change 1 cycle after mdc_rise, i.e. 4 cycles after the pin edge.
- wr_strobe and rd_strobe are asserted in the cycle after the mdc_rise that completes the relevant field.
- MDC high and low phases must each be ≥ 4 msoc_clk cycles; slower MDC is unrestricted below TIMEOUT.
- Asserting rstn low mid-frame immediately releases MDIO (asynchronous) and discards the frame.
- A frame arriving while regs are being reset by reg0 bit 15 sees the reset values; the reset completes in one cycle.

## Test plan
- Read ID: preamble 32x1, ST 01, OP 10, PHYAD 1, REGAD 2 -> first TA bit released, second TA bit driven 0, data 16'h0022 MSB first, oe_emdio low after the last bit, rd_strobe one pulse.
- Write then read: write reg 4 = 16'hA5C3 -> wr_strobe pulse with wr_addr=4, wr_data=A5C3; a read of reg 4 returns A5C3. A write of reg 2 = FFFF then a read returns 0022.
- Wrong address: PHYAD 3 read of reg 0 -> oe_emdio stays 0 for the whole frame, no strobes; the next correct frame with a full preamble is answered.
- Short preamble: 31 ones then a read frame -> ignored; repeated with 32 ones -> answered. OP 11 -> frame ignored.
- Soft reset and link: write reg 4 = 1234, write reg0 = 8000 -> reg 4 reads 0 and reg0 reads 1140. Toggling i_link -> reg1 read returns 796D when high, 7969 when low.
- Abort: stop MDC after 8 read data bits -> oe_emdio drops TIMEOUT cycles later. Assert rstn mid-read -> oe_emdio=0 immediately.
